// File: rtl/y_hist_equalizer.sv
// y_hist_equalizer
// Global histogram equalisation of the luma channel. The Y histogram of
// each frame is accumulated in a 256-bin RAM. On frame_end it is scanned
// into a cumulative-distribution mapping LUT, built in a shadow bank. The
// shadow bank is then swapped in for the next frame. Cb/Cr pass through,
// delay-matched to the 2-cycle luma path.
//
// Optional feature macro: HE_CLIP_EN. When it is defined, each bin
// contributes at most CLIP_LIMIT to the CDF, which gives contrast limiting.
module y_hist_equalizer #(
  parameter int          FRAME_PIXELS = 307200,
  parameter logic [31:0] RECIP        = 32'((64'd255 << 24) / FRAME_PIXELS),
  parameter int          CLIP_LIMIT   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end,
  input  logic       in_valid,
  input  logic [7:0] y_in,
  input  logic [7:0] cb_in,
  input  logic [7:0] cr_in,
  output logic       out_valid,
  output logic [7:0] y_out,
  output logic [7:0] cb_out,
  output logic [7:0] cr_out,
  output logic       lut_valid,
  output logic       busy
);

  localparam int BW = $clog2(FRAME_PIXELS + 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  // Parameter sanity: a non-positive clip ceiling would zero every CDF.
  if (CLIP_LIMIT < 1) begin : g_bad_clip_limit
    $error("CLIP_LIMIT must be at least 1");
  end

  // Control state
  logic [1:0]    state_reg;
  logic [7:0]    clr_cnt_reg;
  logic [8:0]    scan_cnt_reg;
  logic [BW-1:0] cdf_reg;
  logic          bank_sel_reg;
  logic          lut_valid_reg;

  // Histogram RAM and its read/write ports
  logic [BW-1:0] hist_mem [0:255];
  logic [BW-1:0] hist_rd_data;
  logic [7:0]    hist_rd_addr;
  logic [7:0]    hist_rd_addr_reg;
  logic          hist_wr_en;
  logic [7:0]    hist_wr_addr;
  logic [BW-1:0] hist_wr_data;

  // The write committed on the previous edge. It forwards into a read
  // that was issued on the same edge and so saw the old RAM contents.
  logic          last_wr_en_reg;
  logic [7:0]    last_wr_addr_reg;
  logic [BW-1:0] last_wr_data_reg;

  // Accumulate and scan datapath
  logic          acc_valid_reg;
  logic [BW-1:0] bin_val;
  logic [BW-1:0] acc_inc;
  logic          scan_data;
  logic [BW-1:0] contrib;
  logic [BW:0]   cdf_sum;
  logic [BW-1:0] cdf_next;
  logic [BW+31:0] prod;
  logic [BW+7:0]  scaled;
  logic [7:0]     lut_wr_data;

  // LUT banks: bit 8 of the address selects the bank
  logic [7:0] lut_mem [0:511];
  logic [7:0] lut_rd_data;

  // Pixel pipeline registers
  logic       pix_valid_reg;
  logic [7:0] pix_y_reg;
  logic [7:0] pix_cb_reg;
  logic [7:0] pix_cr_reg;
  logic       pix_bank_reg;
  logic       pix_map_reg;
  logic       out_valid_reg;
  logic [7:0] y_pass_reg;
  logic [7:0] cb_out_reg;
  logic [7:0] cr_out_reg;
  logic       map_sel_reg;

  // Histogram read address: the scan pointer while scanning, otherwise the pixel
  always_comb begin
    hist_rd_addr = y_in;
    if (state_reg == ST_SCAN) begin
      hist_rd_addr = scan_cnt_reg[7:0];
    end
  end

  // Bin value with forwarding, plus its saturating increment
  always_comb begin
    bin_val = hist_rd_data;
    if (last_wr_en_reg && (last_wr_addr_reg == hist_rd_addr_reg)) begin
      bin_val = last_wr_data_reg;
    end
    acc_inc = (bin_val == {BW{1'b1}}) ? bin_val : bin_val + BW'(1);
  end

  // Scan data is valid in SCAN cycles 1..256, for bin (scan_cnt - 1)
  assign scan_data = (state_reg == ST_SCAN) && (scan_cnt_reg != 9'd0);

  // Per-bin CDF contribution, clipped when contrast limiting is built in
  always_comb begin
    contrib = bin_val;
`ifdef HE_CLIP_EN
    if ({{(32-BW){1'b0}}, bin_val} > 32'(CLIP_LIMIT)) begin
      contrib = BW'(CLIP_LIMIT);
    end
`else
    contrib = bin_val;
`endif
  end

  // Saturating CDF update and scaled LUT entry
  always_comb begin
    cdf_sum     = {1'b0, cdf_reg} + {1'b0, contrib};
    cdf_next    = cdf_sum[BW] ? {BW{1'b1}} : cdf_sum[BW-1:0];
    prod        = {{32{1'b0}}, cdf_next} * {{BW{1'b0}}, RECIP};
    scaled      = (BW+8)'(prod >> 24);
    lut_wr_data = (scaled > (BW+8)'(255)) ? 8'hFF : scaled[7:0];
  end

  // Single histogram write port: clear has priority, then scan-consume, then count
  always_comb begin
    hist_wr_en   = 1'b0;
    hist_wr_addr = hist_rd_addr_reg;
    hist_wr_data = '0;
    if (state_reg == ST_CLEAR) begin
      hist_wr_en   = 1'b1;
      hist_wr_addr = clr_cnt_reg;
    end else if (scan_data) begin
      hist_wr_en   = 1'b1;
      hist_wr_addr = hist_rd_addr_reg;
    end else if (acc_valid_reg) begin
      hist_wr_en   = 1'b1;
      hist_wr_addr = hist_rd_addr_reg;
      hist_wr_data = acc_inc;
    end
  end

  // Histogram RAM: one write port, registered read (read-before-write)
  always_ff @(posedge clk) begin
    if (hist_wr_en) begin
      hist_mem[hist_wr_addr] <= hist_wr_data;
    end
    hist_rd_data <= hist_mem[hist_rd_addr];
  end

  // LUT RAM: the scan writes the shadow bank, and the pixel path reads the bank latched with it
  always_ff @(posedge clk) begin
    if (scan_data) begin
      lut_mem[{~bank_sel_reg, hist_rd_addr_reg}] <= lut_wr_data;
    end
    lut_rd_data <= lut_mem[{pix_bank_reg, pix_y_reg}];
  end

  // Control FSM: clear -> accumulate -> scan -> swap -> accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_CLEAR;
      clr_cnt_reg   <= 8'd0;
      scan_cnt_reg  <= 9'd0;
      cdf_reg       <= '0;
      bank_sel_reg  <= 1'b0;
      lut_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 8'd1;
          if (clr_cnt_reg == 8'd255) begin
            state_reg <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (frame_end) begin
            state_reg    <= ST_SCAN;
            scan_cnt_reg <= 9'd0;
            cdf_reg      <= '0;
          end
        end
        ST_SCAN: begin
          scan_cnt_reg <= scan_cnt_reg + 9'd1;
          if (scan_data) begin
            cdf_reg <= cdf_next;
          end
          if (scan_cnt_reg == 9'd256) begin
            state_reg <= ST_SWAP;
          end
        end
        default: begin
          bank_sel_reg  <= ~bank_sel_reg;
          lut_valid_reg <= 1'b1;
          state_reg     <= ST_ACCUM;
        end
      endcase
    end
  end

  // Count pipeline: pixels are counted only in ACCUM; also track the last write for forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid_reg    <= 1'b0;
      hist_rd_addr_reg <= 8'd0;
      last_wr_en_reg   <= 1'b0;
      last_wr_addr_reg <= 8'd0;
      last_wr_data_reg <= '0;
    end else begin
      acc_valid_reg    <= in_valid && (state_reg == ST_ACCUM);
      hist_rd_addr_reg <= hist_rd_addr;
      last_wr_en_reg   <= hist_wr_en;
      last_wr_addr_reg <= hist_wr_addr;
      last_wr_data_reg <= hist_wr_data;
    end
  end

  // Pixel stage 1: LUT address register, with the bank and map-enable frozen per pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_reg <= 1'b0;
      pix_y_reg     <= 8'd0;
      pix_cb_reg    <= 8'd0;
      pix_cr_reg    <= 8'd0;
      pix_bank_reg  <= 1'b0;
      pix_map_reg   <= 1'b0;
    end else begin
      pix_valid_reg <= in_valid;
      pix_y_reg     <= y_in;
      pix_cb_reg    <= cb_in;
      pix_cr_reg    <= cr_in;
      pix_bank_reg  <= bank_sel_reg;
      pix_map_reg   <= lut_valid_reg;
    end
  end

  // Pixel stage 2: output register alongside the registered LUT read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      y_pass_reg    <= 8'd0;
      cb_out_reg    <= 8'd0;
      cr_out_reg    <= 8'd0;
      map_sel_reg   <= 1'b0;
    end else begin
      out_valid_reg <= pix_valid_reg;
      y_pass_reg    <= pix_y_reg;
      cb_out_reg    <= pix_cb_reg;
      cr_out_reg    <= pix_cr_reg;
      map_sel_reg   <= pix_map_reg;
    end
  end

  assign out_valid = out_valid_reg;
  assign y_out     = map_sel_reg ? lut_rd_data : y_pass_reg;
  assign cb_out    = cb_out_reg;
  assign cr_out    = cr_out_reg;
  assign lut_valid = lut_valid_reg;
  assign busy      = (state_reg != ST_ACCUM);

endmodule

// File: tb/tb_y_hist_equalizer.sv
// Scoreboard bench for y_hist_equalizer (FRAME_PIXELS = 256).
// Define HE_CLIP_EN for both files to run the clipped variant (CLIP_LIMIT = 64).
module tb_y_hist_equalizer;

`ifdef HE_CLIP_EN
  localparam int CLIP    = 64;
  localparam int LIM     = 63;   // LUT value at and above the constant bin
  localparam int S6_Y0   = 63;
  localparam int S6_Y254 = 63;
  localparam int S6_Y255 = 64;
`else
  localparam int CLIP    = 4096;
  localparam int LIM     = 255;
  localparam int S6_Y0   = 254;
  localparam int S6_Y254 = 254;
  localparam int S6_Y255 = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_end = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] y_in = 8'd0;
  logic [7:0] cb_in = 8'd0;
  logic [7:0] cr_in = 8'd0;
  logic       out_valid;
  logic [7:0] y_out;
  logic [7:0] cb_out;
  logic [7:0] cr_out;
  logic       lut_valid;
  logic       busy;

  y_hist_equalizer #(
    .FRAME_PIXELS(256),
    .RECIP       (32'd16711680),
    .CLIP_LIMIT  (CLIP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_end(frame_end),
    .in_valid (in_valid),
    .y_in     (y_in),
    .cb_in    (cb_in),
    .cr_in    (cr_in),
    .out_valid(out_valid),
    .y_out    (y_out),
    .cb_out   (cb_out),
    .cr_out   (cr_out),
    .lut_valid(lut_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    bit         chk;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a pixel
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("y_out", 32'(y_out), 32'(e.y));
          check("cb_out", 32'(cb_out), 32'(e.cb));
          check("cr_out", 32'(cr_out), 32'(e.cr));
          check("latency", 32'(cyc - e.cyc), 32'd2);
          $display("pix: y_out=%0d cb=%02h cr=%02h (exp y=%0d chk=%0d)", y_out, cb_out, cr_out, e.y, e.chk);
        end
      end
    end
  end

  // Drive one cycle of inputs; a valid pixel pushes its expected output
  task automatic drive(input bit v, input logic [7:0] y, input logic [7:0] cb,
                       input logic [7:0] cr, input bit fe, input bit chk, input logic [7:0] ey);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    y_in      = y;
    cb_in     = cb;
    cr_in     = cr;
    frame_end = fe;
    if (v) begin
      e.y = ey; e.cb = cb; e.cr = cr; e.chk = chk; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic probe(input logic [7:0] y, input logic [7:0] ey);
    drive(1'b1, y, 8'h5A, 8'hA5, 1'b0, 1'b1, ey);
  endtask

  // Reset (possibly mid-operation); outputs and flags must drop at once
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    frame_end = 1'b0;
    sb.delete();
    #1;
    check("rst_lut_valid", 32'(lut_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_clear", 32'(busy), 32'd0);
  endtask

  // Count busy cycles after frame_end; optionally inject SCAN-time pixels and frame_end pulses
  task automatic wait_swap(input int scan_pix, output int busy_cnt);
    bit v;
    bit fe;
    busy_cnt = 0;
    for (int j = 1; j <= 400; j++) begin
      v  = (j >= 5) && (j < 5 + scan_pix);
      fe = (scan_pix > 0) && (j == 10 || j == 60);
      drive(v, 8'(j - 5), 8'h3C, 8'hC3, fe, 1'b1, 8'(j - 5));
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
    end
    idle(1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;

    // Scenario 1: uniform frame gives an identity LUT; identity before the first SWAP
    do_reset();
    wait_ready();
    for (int k = 0; k < 256; k++) drive(1'b1, 8'(k), 8'(k), 8'(255 - k), 1'b0, 1'b1, 8'(k));
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
    wait_swap(0, b);
    check("s1_busy_cycles", 32'(b), 32'd258);
    check("s1_lut_valid", 32'(lut_valid), 32'd1);
    probe(8'd0, 8'd0);
    probe(8'd127, 8'd127);
    probe(8'd255, 8'd255);
    idle(4);

    // Scenarios 2 and 4: back-to-back constant frame; SCAN-time pixels and frame_end ignored
    do_reset();
    wait_ready();
    for (int k = 0; k < 256; k++) drive(1'b1, 8'd100, 8'h3C, 8'hC3, 1'b0, 1'b1, 8'd100);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
    wait_swap(20, b);
    check("s2_busy_cycles", 32'(b), 32'd258);
    probe(8'd99, 8'd0);
    probe(8'd100, 8'(LIM));
    probe(8'd200, 8'(LIM));
    probe(8'd255, 8'(LIM));
    probe(8'd0, 8'd0);
    idle(4);

    // Scenario 5: abort the SCAN of a y=99 frame at cycle 100, then rebuild from scratch
    for (int k = 0; k < 256; k++) drive(1'b1, 8'd99, 8'h3C, 8'hC3, 1'b0, 1'b1, 8'd0);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
    idle(100);
    do_reset();
    wait_ready();
    for (int k = 0; k < 256; k++) drive(1'b1, 8'd100, 8'h3C, 8'hC3, 1'b0, 1'b1, 8'd100);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
    wait_swap(0, b);
    check("s5_busy_cycles", 32'(b), 32'd258);
    probe(8'd99, 8'd0);
    probe(8'd100, 8'(LIM));
    probe(8'd200, 8'(LIM));
    idle(4);

    // Scenario 6: final pixel coincident with frame_end is still counted
    do_reset();
    wait_ready();
    for (int k = 0; k < 255; k++) drive(1'b1, 8'd0, 8'h11, 8'h22, 1'b0, 1'b1, 8'd0);
    drive(1'b1, 8'd255, 8'h11, 8'h22, 1'b1, 1'b1, 8'd255);
    wait_swap(0, b);
    check("s6_busy_cycles", 32'(b), 32'd258);
    probe(8'd0, 8'(S6_Y0));
    probe(8'd254, 8'(S6_Y254));
    probe(8'd255, 8'(S6_Y255));
    idle(6);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y_hist_equalizer.md
# y_hist_equalizer

Global histogram equalisation of the luma channel, inserted between `rgb_to_ycbcr` and `ycbcr_to_rgb` in the Retinex_HE pipeline. Each frame's Y histogram is accumulated and converted to a 256-entry mapping LUT during vertical blanking. The LUT is applied to the next frame's Y samples. Cb/Cr are delay-matched and passed through unchanged.

## Interface
- `FRAME_PIXELS`, 307200: nominal pixels per frame; sets bin width `BW = $clog2(FRAME_PIXELS+1)`.
- `RECIP`, `(255*2**24)/FRAME_PIXELS`: LUT scale constant, integer, truncated.
- `CLIP_LIMIT`, 4096: per-bin clip ceiling; only used with `HE_CLIP_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_end` in 1: single-cycle pulse marking the end of the active frame; starts the LUT build.
- `in_valid` in 1: qualifies `y_in`/`cb_in`/`cr_in`.
- `y_in`, `cb_in`, `cr_in` in 8 each: pixel from `rgb_to_ycbcr`.
- `out_valid` out 1: `in_valid` delayed by 2 cycles.
- `y_out` out 8: equalised luma.
- `cb_out`, `cr_out` out 8 each: chroma delayed by 2 cycles.
- `lut_valid` out 1: high once the first LUT has been built.
- `busy` out 1: high in CLEAR, SCAN and SWAP.

## Operation
- Storage:
  - histogram RAM: 256×BW, synchronous read.
  - two LUT banks: 256×8, one active and one shadow; `bank_sel` selects the active bank.
- FSM states: CLEAR → ACCUM → SCAN → SWAP → ACCUM.
- **CLEAR** (entered from reset): writes 0 to bins 0..255 over 256 cycles, then goes to ACCUM.
- **ACCUM**: each `in_valid` increments `hist[y_in]`.
  - Read-modify-write is pipelined with forwarding, so back-to-back equal `y_in` values count exactly.
  - Bins saturate at `2**BW-1`.
- **SCAN**: entered on `frame_end` in ACCUM. Runs 257 cycles (read address k in cycle k; data in cycle k+1).
  - `cdf += bin`.
  - Shadow LUT entry k is written as `min(255, (cdf*RECIP) >> 24)`.
  - Bin k is written to 0 as it is consumed.
  - Product width is `BW+32` bits; `cdf` is BW bits and saturating.
- **SWAP** (1 cycle): toggles `bank_sel`, sets `lut_valid = 1`, then returns to ACCUM.
- Pixel path runs in every state, using the active bank.
  - If `lut_valid = 0`, `y_out = y_in` (identity).
- Pixels arriving in CLEAR, SCAN or SWAP are mapped but not counted.
- `frame_end` in CLEAR, SCAN or SWAP is ignored.
- `frame_end` coincident with a final `in_valid` pixel: that pixel is counted, then SCAN starts.

## Timing
- Pixel latency is 2 cycles for all outputs: LUT address register, then output register.
- The LUT swap takes effect for pixels whose address register loads after the SWAP cycle. No pixel ever sees a mixed-bank read.
- Frame-end to new LUT active: 258 cycles (257 SCAN + 1 SWAP). Blanking must be at least 258 cycles for the LUT to be ready before the next frame.
- Reset values (asynchronous):
  - `out_valid`, `y_out`, `cb_out`, `cr_out`, `lut_valid`, `bank_sel` = 0.
  - `busy` = 1, state = CLEAR, scan and clear counters = 0.
- Reset asserted mid-SCAN: the partial LUT is discarded, `lut_valid` = 0, and the histogram is re-cleared.
- LUT RAM contents are not reset; `lut_valid` gates their use.

## Configuration
- `HE_CLIP_EN` defined: in SCAN each bin contributes `min(bin, CLIP_LIMIT)` to `cdf`. Excess is discarded, not redistributed, so the LUT maximum may be below 255 (intended contrast limiting).
- `HE_CLIP_EN` undefined: raw bins are summed; `CLIP_LIMIT` is unused and no comparator is synthesised.

## Test plan
All scenarios use `FRAME_PIXELS = 256` (`RECIP = 16711680`) unless noted.
1. After reset, wait for `busy` = 0. Stream y = 0..255, each once, then `frame_end`.
   - `busy` is high for exactly 258 cycles.
   - Next frame: y_in 0 → 0, 127 → 127, 255 → 255.
   - Before the first SWAP, `y_out == y_in`.
2. Constant frame of 256 pixels with y = 100, sent with `in_valid` back-to-back.
   - Next frame: y_in 99 → 0, y_in 100 → 255, y_in 200 → 255 (checks forwarding).
3. Same stimulus as scenario 2 with `HE_CLIP_EN` and `CLIP_LIMIT = 64`.
   - y_in 100 → 63; y_in 255 → 63.
4. Pixels with cb = 0x3C, cr = 0xC3 sent during SCAN and during ACCUM.
   - Chroma arrives 2 cycles later, unchanged.
   - SCAN-time pixels do not alter the following frame's LUT.
   - `frame_end` pulses during SCAN are ignored.
5. Assert `rst_n` low at SCAN cycle 100, release, then send the scenario-2 frame.
   - `lut_valid` drops to 0 immediately; identity mapping until the new SWAP.
   - Resulting LUT matches scenario 2 (no stale bins).
6. Last pixel (y = 255) coincident with `frame_end`, frame = 255 × y0 + 1 × y255.
   - y255 is counted: LUT[254] = 254, LUT[255] = 255.
